// File: rtl/opcode_tag_allocator.sv
// ---------------------------------------------------------------------------
// opcode_tag_allocator
//
// Hands out unique 9-bit opcode tags to incoming commands and takes them back
// when the command completes. Every opcode class owns its own pool of
// NUM_TAGS slots. A tag is {class, slot}, so downstream logic recovers the
// class from tag[8:6] and the slot from tag[5:0]
// (READ=0x000.., WRITE=0x040.., WAIT=0x080.., EVICT=0x0C0.., TRIM=0x100..).
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    command request valid
//   req_ready    request accepted when high together with req_valid
//   req_opcode   opcode class of the request (0..4 legal, 5..7 illegal)
//   tag_valid    allocated tag valid (registered)
//   tag_ready    downstream accepts tag
//   tag_out      allocated tag (registered)
//   rel_valid    tag release strobe, never back-pressured
//   rel_tag      tag being released
//   err          one-cycle pulses: bit0 bad release, bit1 illegal opcode
//   pool_empty   per class, 1 = no free tag
// ---------------------------------------------------------------------------
module opcode_tag_allocator #(
    parameter int unsigned NUM_TAGS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_opcode,
    output logic       tag_valid,
    input  logic       tag_ready,
    output logic [8:0] tag_out,
    input  logic       rel_valid,
    input  logic [8:0] rel_tag,
    output logic [1:0] err,
    output logic [4:0] pool_empty
);

    // Fixed by the opcode class set; deliberately not a parameter.
    localparam int unsigned NUM_TYPES = 5;

    typedef enum logic [2:0] {
        OP_READ  = 3'd0,
        OP_WRITE = 3'd1,
        OP_WAIT  = 3'd2,
        OP_EVICT = 3'd3,
        OP_TRIM  = 3'd4
    } opcodeEnumT;

    generate
        if (NUM_TAGS < 1 || NUM_TAGS > 64) begin : gBadNumTags
            $error("opcode_tag_allocator: NUM_TAGS must be within 1..64");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NUM_TAGS-1:0] busy     [NUM_TYPES];
    logic [NUM_TAGS-1:0] busyNext [NUM_TYPES];

    // -----------------------------------------------------------------------
    // Request side decode
    // -----------------------------------------------------------------------
    logic                reqLegal;
    logic [NUM_TAGS-1:0] reqRow;
    logic                reqRowFull;
    logic                freeFound;
    logic [5:0]          freeIdx;
    logic                outFree;
    logic                accept;
    logic                allocGo;
    logic                illegalGo;

    assign reqLegal = (req_opcode <= OP_TRIM);
    assign outFree  = !tag_valid || tag_ready;

    // Bitmap row of the requested class; an illegal class reads as all-busy
    // so no slot can ever be picked for it.
    always_comb begin
        reqRow = '1;
        for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            if (req_opcode == 3'(t)) begin
                reqRow = busy[t];
            end
        end
    end

    assign reqRowFull = &reqRow;

    // Lowest free slot in the requested row, taken from the pre-release
    // bitmap so a same-cycle release never feeds the allocator.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (!freeFound && !reqRow[i]) begin
                freeFound = 1'b1;
                freeIdx   = 6'(i);
            end
        end
    end

    // req_ready depends on req_opcode but never on req_valid.
    assign req_ready = reqLegal ? (outFree && !reqRowFull) : outFree;

    assign accept    = req_valid && req_ready;
    assign allocGo   = accept && reqLegal && freeFound;
    assign illegalGo = accept && !reqLegal;

    // -----------------------------------------------------------------------
    // Release side decode
    // -----------------------------------------------------------------------
    logic [2:0] relType;
    logic [5:0] relSlot;
    logic       relHit;
    logic       relOk;
    logic       relBad;

    assign relType = rel_tag[8:6];
    assign relSlot = rel_tag[5:0];

    // A release is good only if it names an existing class and slot whose
    // busy bit is set; anything else (double release, slot beyond NUM_TAGS,
    // class 5..7) falls through to relHit = 0.
    always_comb begin
        relHit = 1'b0;
        for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                if (relType == 3'(t) && relSlot == 6'(i) && busy[t][i]) begin
                    relHit = 1'b1;
                end
            end
        end
    end

    assign relOk  = rel_valid && relHit;
    assign relBad = rel_valid && !relHit;

    // -----------------------------------------------------------------------
    // Next bitmap: clear and set land on the same edge. The set targets a
    // bit that is currently free and the clear a bit that is currently busy,
    // so they never collide.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            busyNext[t] = busy[t];
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                if (relOk && relType == 3'(t) && relSlot == 6'(i)) begin
                    busyNext[t][i] = 1'b0;
                end
                if (allocGo && req_opcode == 3'(t) && freeIdx == 6'(i)) begin
                    busyNext[t][i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < NUM_TYPES; t++) begin
                busy[t] <= '0;
            end
        end else begin
            for (int unsigned t = 0; t < NUM_TYPES; t++) begin
                busy[t] <= busyNext[t];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pool status, combinational from the registered bitmap
    // -----------------------------------------------------------------------
    always_comb begin
        pool_empty = '0;
        for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            pool_empty[t] = &busy[t];
        end
    end

    // -----------------------------------------------------------------------
    // Output stage and error pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= 1'b0;
            tag_out   <= '0;
            err       <= '0;
        end else begin
            if (allocGo) begin
                tag_valid <= 1'b1;
                tag_out   <= {req_opcode, freeIdx};
            end else if (tag_ready) begin
                tag_valid <= 1'b0;
            end
            err <= {illegalGo, relBad};
        end
    end

endmodule

// File: tb/tb_opcode_tag_allocator.sv
// ---------------------------------------------------------------------------
// tb_opcode_tag_allocator
//
// Directed bench for opcode_tag_allocator (NUM_TAGS = 16). Inputs change 1 ns
// after the rising edge; registered outputs are sampled there as well, and
// combinational outputs 1 ns after the inputs settle.
// ---------------------------------------------------------------------------
module tb_opcode_tag_allocator;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_opcode;
    logic       tag_valid;
    logic       tag_ready;
    logic [8:0] tag_out;
    logic       rel_valid;
    logic [8:0] rel_tag;
    logic [1:0] err;
    logic [4:0] pool_empty;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    opcode_tag_allocator #(.NUM_TAGS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .tag_valid  (tag_valid),
        .tag_ready  (tag_ready),
        .tag_out    (tag_out),
        .rel_valid  (rel_valid),
        .rel_tag    (rel_tag),
        .err        (err),
        .pool_empty (pool_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string name, input logic [31:0] got,
                           input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyReset();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 3'd0;
        tag_ready  = 1'b0;
        rel_valid  = 1'b0;
        rel_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 3'd0;
        tag_ready  = 1'b0;
        rel_valid  = 1'b0;
        rel_tag    = '0;

        // ---------------- reset state ----------------
        applyReset();
        checkEq("rst_tag_valid", 32'(tag_valid), 32'd0);
        checkEq("rst_tag_out", 32'(tag_out), 32'h000);
        checkEq("rst_err", 32'(err), 32'd0);
        checkEq("rst_pool_empty", 32'(pool_empty), 32'h00);

        // ---------------- 1: READ, WRITE, TRIM back to back ----------------
        tag_ready  = 1'b1;
        req_valid  = 1'b1;
        req_opcode = 3'd0;
        settle();
        checkEq("t1_ready_read", 32'(req_ready), 32'd1);
        tick();
        checkEq("t1_tag_read", 32'(tag_out), 32'h000);
        checkEq("t1_valid_read", 32'(tag_valid), 32'd1);
        req_opcode = 3'd1;
        tick();
        checkEq("t1_tag_write", 32'(tag_out), 32'h040);
        checkEq("t1_valid_write", 32'(tag_valid), 32'd1);
        req_opcode = 3'd4;
        tick();
        checkEq("t1_tag_trim", 32'(tag_out), 32'h100);
        checkEq("t1_valid_trim", 32'(tag_valid), 32'd1);
        req_valid = 1'b0;
        tick();
        checkEq("t1_valid_drop", 32'(tag_valid), 32'd0);

        // ---------------- 2: exhaust WAIT pool, release 0x085 ----------------
        applyReset();
        tag_ready  = 1'b1;
        req_valid  = 1'b1;
        req_opcode = 3'd2;
        for (int k = 0; k < 16; k++) begin
            settle();
            checkEq("t2_ready_fill", 32'(req_ready), 32'd1);
            tick();
            checkEq("t2_tag_fill", 32'(tag_out), 32'h080 + 32'(k));
        end
        settle();
        checkEq("t2_ready_17th", 32'(req_ready), 32'd0);
        checkEq("t2_pool_empty_full", 32'(pool_empty), 32'h04);
        tick();
        checkEq("t2_valid_after_fill", 32'(tag_valid), 32'd0);
        rel_valid = 1'b1;
        rel_tag   = 9'h085;
        settle();
        checkEq("t2_pool_empty_rel_cycle", 32'(pool_empty), 32'h04);
        checkEq("t2_ready_rel_cycle", 32'(req_ready), 32'd0);
        tick();
        rel_valid = 1'b0;
        settle();
        checkEq("t2_err_good_rel", 32'(err), 32'd0);
        checkEq("t2_pool_empty_after_rel", 32'(pool_empty), 32'h00);
        checkEq("t2_ready_after_rel", 32'(req_ready), 32'd1);
        checkEq("t2_valid_after_rel", 32'(tag_valid), 32'd0);
        tick();
        checkEq("t2_tag_reissue", 32'(tag_out), 32'h085);
        checkEq("t2_valid_reissue", 32'(tag_valid), 32'd1);
        checkEq("t2_pool_empty_refull", 32'(pool_empty), 32'h04);
        req_valid = 1'b0;
        tick();

        // ---------------- 3: backpressure on tag_ready ----------------
        applyReset();
        tag_ready  = 1'b0;
        req_valid  = 1'b1;
        req_opcode = 3'd0;
        settle();
        checkEq("t3_ready_first", 32'(req_ready), 32'd1);
        tick();
        checkEq("t3_tag_first", 32'(tag_out), 32'h000);
        checkEq("t3_ready_stalled", 32'(req_ready), 32'd0);
        tick();
        checkEq("t3_tag_stable", 32'(tag_out), 32'h000);
        checkEq("t3_valid_stable", 32'(tag_valid), 32'd1);
        checkEq("t3_ready_still_stalled", 32'(req_ready), 32'd0);
        tag_ready = 1'b1;
        settle();
        checkEq("t3_ready_unstalled", 32'(req_ready), 32'd1);
        tick();
        checkEq("t3_tag_second", 32'(tag_out), 32'h001);
        checkEq("t3_valid_second", 32'(tag_valid), 32'd1);
        req_valid = 1'b0;
        tick();
        checkEq("t3_valid_drain", 32'(tag_valid), 32'd0);

        // ---------------- 4: bad releases and release/alloc overlap ----------------
        applyReset();
        tag_ready  = 1'b1;
        req_valid  = 1'b1;
        req_opcode = 3'd0;
        tick();
        checkEq("t4_tag_r0", 32'(tag_out), 32'h000);
        req_valid = 1'b0;
        rel_valid = 1'b1;
        rel_tag   = 9'h041;
        tick();
        checkEq("t4_err_unalloc", 32'(err), 32'h1);
        rel_tag = 9'h14F;
        tick();
        checkEq("t4_err_type5", 32'(err), 32'h1);
        rel_tag = 9'h010;
        tick();
        checkEq("t4_err_slot_range", 32'(err), 32'h1);
        rel_valid = 1'b0;
        tick();
        checkEq("t4_err_clear", 32'(err), 32'h0);
        checkEq("t4_pool_empty", 32'(pool_empty), 32'h00);
        req_valid  = 1'b1;
        req_opcode = 3'd0;
        tick();
        checkEq("t4_tag_r1", 32'(tag_out), 32'h001);
        req_opcode = 3'd1;
        tick();
        checkEq("t4_tag_w0", 32'(tag_out), 32'h040);
        // Release 0x000 while requesting READ: pre-release bitmap wins.
        req_opcode = 3'd0;
        rel_valid  = 1'b1;
        rel_tag    = 9'h000;
        tick();
        checkEq("t4_tag_overlap", 32'(tag_out), 32'h002);
        checkEq("t4_err_overlap", 32'(err), 32'h0);
        rel_valid = 1'b0;
        tick();
        checkEq("t4_tag_freed", 32'(tag_out), 32'h000);
        req_valid = 1'b0;
        rel_valid = 1'b1;
        rel_tag   = 9'h040;
        tick();
        checkEq("t4_err_good_w0", 32'(err), 32'h0);
        tick();
        checkEq("t4_err_double", 32'(err), 32'h1);
        rel_valid = 1'b0;
        tick();

        // ---------------- 5: illegal opcode ----------------
        applyReset();
        tag_ready  = 1'b1;
        req_valid  = 1'b1;
        req_opcode = 3'd6;
        settle();
        checkEq("t5_ready_illegal", 32'(req_ready), 32'd1);
        tick();
        checkEq("t5_err_illegal", 32'(err), 32'h2);
        checkEq("t5_valid_illegal", 32'(tag_valid), 32'd0);
        req_opcode = 3'd7;
        rel_valid  = 1'b1;
        rel_tag    = 9'h041;
        tick();
        checkEq("t5_err_both", 32'(err), 32'h3);
        checkEq("t5_valid_both", 32'(tag_valid), 32'd0);
        req_valid = 1'b0;
        rel_valid = 1'b0;
        tick();
        checkEq("t5_err_clear", 32'(err), 32'h0);
        checkEq("t5_pool_empty", 32'(pool_empty), 32'h00);

        // ---------------- 6: async reset mid-stream ----------------
        applyReset();
        tag_ready  = 1'b1;
        req_valid  = 1'b1;
        req_opcode = 3'd3;
        tick();
        tick();
        tick();
        checkEq("t6_tag_e2", 32'(tag_out), 32'h0C2);
        #3;
        rst_n = 1'b0;
        #1;
        checkEq("t6_async_valid", 32'(tag_valid), 32'd0);
        checkEq("t6_async_tag", 32'(tag_out), 32'h000);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        req_valid  = 1'b1;
        req_opcode = 3'd3;
        settle();
        checkEq("t6_ready_after", 32'(req_ready), 32'd1);
        tick();
        checkEq("t6_tag_after", 32'(tag_out), 32'h0C0);
        checkEq("t6_valid_after", 32'(tag_valid), 32'd1);
        req_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
